laser_marker_overlay: RTL
=========================

Name: laser_marker_overlay

Overview:
Consumer of the detector's packed laser coordinate: draws a crosshair marker at the laser position into the outgoing pixel stream for on-screen aiming feedback. Sits after the laser detector in the image processing IP, on the same pixel stream (en/pixel_col/pixel_row/data). Latches coordinates only at frame start so the marker never tears. Coasts (blinking) on the last known position when the target is lost, then hides it.

Parameters:
ARM_LEN, 8, crosshair half-length in pixels (arm covers |delta| <= ARM_LEN)
COAST_FRAMES, 30, consecutive missed frames before marker is dropped (1..255)
BLINK_FRAMES, 8, frames per blink half-period while coasting (1..255)

Ports:
clk  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
en  input  1  pixel valid / advance strobe
pixel_col  input  16  column of current input pixel
pixel_row  input  16  row of current input pixel
data  input  `PIXEL_SIZE  input pixel, {R[23:16],B[15:8],G[7:0]}
laser_xy  input  32  {laser_x[31:16], laser_y[15:0]}
xy_valid  input  1  laser coordinate valid for the frame just finished
marker_color  input  `PIXEL_SIZE  colour written on marker pixels
data_out  output  `PIXEL_SIZE  output pixel
out_en  output  1  en delayed one cycle
out_col  output  16  pixel_col delayed one cycle
out_row  output  16  pixel_row delayed one cycle
marker_state  output  2  current FSM state (debug)

Behaviour:
- Reset (async, reset_n=0): data_out=0, out_en=0, out_col=0, out_row=0, state=NO_TARGET (2'd0), mark_x=mark_y=0, miss_cnt=0, blink_cnt=0, blink_on=1.
- sof = en && pixel_col==0 && pixel_row==0. All FSM/coordinate updates occur only on the sof cycle; en=0 freezes everything except output pipeline (out_en follows en).
- States: NO_TARGET=0, TRACK=1, COAST=2 (3 unused -> NO_TARGET next sof).
  - NO_TARGET: xy_valid -> TRACK, latch mark_x/mark_y from laser_xy, miss_cnt=0.
  - TRACK: xy_valid -> stay, re-latch. Else -> COAST, miss_cnt=1, coords held, blink_cnt=0, blink_on=1.
  - COAST: xy_valid -> TRACK, re-latch, miss_cnt=0. Else miss_cnt+1; if miss_cnt+1 == COAST_FRAMES -> NO_TARGET, miss_cnt=0.
- Blink (COAST only, on sof): blink_cnt+1; when it reaches BLINK_FRAMES, blink_cnt=0 and blink_on toggles. Outside COAST, blink_on held at 1.
- Draw condition, evaluated on current pixel with latched coords: dx=|pixel_col-mark_x|, dy=|pixel_row-mark_y|, computed 17-bit, no wrap (marker at col 0 with ARM_LEN 8 draws cols 0..8 only, never col 65535). hit = (dy==0 && dx<=ARM_LEN) || (dx==0 && dy<=ARM_LEN).
- draw = hit && (state==TRACK || (state==COAST && blink_on)).
- sof pixel uses state/coords BEFORE the sof update (new coords take effect from the next pixel).
- Latency: exactly 1 cycle. When en=1: data_out <= draw ? marker_color : data; out_col/out_row <= inputs. When en=0: data_out/out_col/out_row hold; out_en <= 0.
- laser_xy/xy_valid changes between sof cycles have no visible effect.
- Reset mid-frame: outputs clear immediately; marker absent until next sof with xy_valid=1.

Test Plan:
- Reset, then sof with xy_valid=1, laser_xy={16'd100,16'd50}; stream row 50 -> data_out=marker_color at cols 92..108, input data elsewhere; col 100 rows 42..58 marked; one-cycle latency.
- Frame with xy_valid=1 latched, then mid-frame change laser_xy to {200,200} -> marker stays at (100,50) until next sof.
- TRACK then xy_valid=0 on sof -> marker_state=2; frames 0..7 marker shown, 8..15 hidden, 16..23 shown (BLINK_FRAMES=8).
- 30 consecutive sof with xy_valid=0 from TRACK -> marker_state=0 after 30th sof, no marker; xy_valid=1 on 29th -> back to TRACK, solid marker.
- Marker at (3,0): row 0 cols 0..11 marked, no pixels at col 65531+ or row 65535 marked.
- Assert reset_n low mid-row for 1 cycle -> data_out=0, out_en=0 asynchronously; next frame passes input unchanged until valid sof.

Source files
------------

// File: rtl/laser_marker_overlay.sv
`default_nettype none
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif
// ============================================================================
// Module      : laser_marker_overlay
// Description : Draws a crosshair marker at the detected laser position into
//               the pixel stream. Coordinates are latched only at start of
//               frame (pixel 0,0 with en) so the marker never tears. When the
//               target is lost the marker blinks on the last known position,
//               then is dropped after COAST_FRAMES missed frames.
// Ports       : clk, reset_n (async, active low)
//               en/pixel_col/pixel_row/data   - input pixel stream
//               laser_xy {x[31:16],y[15:0]}   - coordinate from detector
//               xy_valid                      - coordinate valid, sampled at sof
//               marker_color                  - colour of marker pixels
//               data_out/out_en/out_col/out_row - stream delayed one cycle
//               marker_state                  - FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module laser_marker_overlay #(
  parameter int ARM_LEN      = 8,
  parameter int COAST_FRAMES = 30,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [15:0]            pixel_col,
  input  logic [15:0]            pixel_row,
  input  logic [`PIXEL_SIZE-1:0] data,
  input  logic [31:0]            laser_xy,
  input  logic                   xy_valid,
  input  logic [`PIXEL_SIZE-1:0] marker_color,
  output logic [`PIXEL_SIZE-1:0] data_out,
  output logic                   out_en,
  output logic [15:0]            out_col,
  output logic [15:0]            out_row,
  output logic [1:0]             marker_state
);

  typedef enum logic [1:0] {
    NO_TARGET = 2'd0,
    TRACK     = 2'd1,
    COAST     = 2'd2
  } state_e;

  localparam logic [16:0] C_ARM_LIM   = 17'(ARM_LEN);
  localparam logic [8:0]  C_COAST_LIM = 9'(COAST_FRAMES);
  localparam logic [8:0]  C_BLINK_LIM = 9'(BLINK_FRAMES);

  state_e                   state_q, state_d;
  logic [15:0]              mark_x_q, mark_x_d;
  logic [15:0]              mark_y_q, mark_y_d;
  logic [7:0]               miss_cnt_q, miss_cnt_d;
  logic [7:0]               blink_cnt_q, blink_cnt_d;
  logic                     blink_on_q, blink_on_d;
  logic [`PIXEL_SIZE-1:0]   data_out_q, data_out_d;
  logic                     out_en_q, out_en_d;
  logic [15:0]              out_col_q, out_col_d;
  logic [15:0]              out_row_q, out_row_d;

  logic        sof;
  logic [16:0] dx, dy;
  logic        hit, draw;
  logic [8:0]  miss_inc, blink_inc;

  assign sof = en && (pixel_col == 16'd0) && (pixel_row == 16'd0);

  // Absolute distance, so a marker near an edge never wraps to the far side.
  assign dx = (pixel_col >= mark_x_q) ? {1'b0, pixel_col - mark_x_q}
                                      : {1'b0, mark_x_q - pixel_col};
  assign dy = (pixel_row >= mark_y_q) ? {1'b0, pixel_row - mark_y_q}
                                      : {1'b0, mark_y_q - pixel_row};

  assign hit  = ((dy == 17'd0) && (dx <= C_ARM_LIM)) ||
                ((dx == 17'd0) && (dy <= C_ARM_LIM));
  // Uses the pre-update state, so the sof pixel still shows the old marker.
  assign draw = hit && ((state_q == TRACK) || ((state_q == COAST) && blink_on_q));

  assign miss_inc  = {1'b0, miss_cnt_q} + 9'd1;
  assign blink_inc = {1'b0, blink_cnt_q} + 9'd1;

  always_comb begin
    state_d     = state_q;
    mark_x_d    = mark_x_q;
    mark_y_d    = mark_y_q;
    miss_cnt_d  = miss_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (sof) begin
      case (state_q)
        NO_TARGET: begin
          if (xy_valid) begin
            state_d    = TRACK;
            mark_x_d   = laser_xy[31:16];
            mark_y_d   = laser_xy[15:0];
            miss_cnt_d = 8'd0;
          end
        end
        TRACK: begin
          if (xy_valid) begin
            mark_x_d = laser_xy[31:16];
            mark_y_d = laser_xy[15:0];
          end else begin
            // A one-frame coast budget means the first miss drops the marker.
            state_d     = (C_COAST_LIM == 9'd1) ? NO_TARGET : COAST;
            miss_cnt_d  = (C_COAST_LIM == 9'd1) ? 8'd0 : 8'd1;
            blink_cnt_d = 8'd0;
            blink_on_d  = 1'b1;
          end
        end
        COAST: begin
          if (xy_valid) begin
            state_d     = TRACK;
            mark_x_d    = laser_xy[31:16];
            mark_y_d    = laser_xy[15:0];
            miss_cnt_d  = 8'd0;
            blink_cnt_d = 8'd0;
            blink_on_d  = 1'b1;
          end else if (miss_inc == C_COAST_LIM) begin
            state_d     = NO_TARGET;
            miss_cnt_d  = 8'd0;
            blink_cnt_d = 8'd0;
            blink_on_d  = 1'b1;
          end else begin
            miss_cnt_d = miss_inc[7:0];
            if (blink_inc == C_BLINK_LIM) begin
              blink_cnt_d = 8'd0;
              blink_on_d  = ~blink_on_q;
            end else begin
              blink_cnt_d = blink_inc[7:0];
            end
          end
        end
        default: begin
          state_d     = NO_TARGET;
          miss_cnt_d  = 8'd0;
          blink_cnt_d = 8'd0;
          blink_on_d  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    out_col_d  = out_col_q;
    out_row_d  = out_row_q;
    out_en_d   = en;
    if (en) begin
      data_out_d = draw ? marker_color : data;
      out_col_d  = pixel_col;
      out_row_d  = pixel_row;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= NO_TARGET;
      mark_x_q    <= 16'd0;
      mark_y_q    <= 16'd0;
      miss_cnt_q  <= 8'd0;
      blink_cnt_q <= 8'd0;
      blink_on_q  <= 1'b1;
      data_out_q  <= '0;
      out_en_q    <= 1'b0;
      out_col_q   <= 16'd0;
      out_row_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      mark_x_q    <= mark_x_d;
      mark_y_q    <= mark_y_d;
      miss_cnt_q  <= miss_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      data_out_q  <= data_out_d;
      out_en_q    <= out_en_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
    end
  end

  assign data_out     = data_out_q;
  assign out_en       = out_en_q;
  assign out_col      = out_col_q;
  assign out_row      = out_row_q;
  assign marker_state = state_q;

endmodule
`default_nettype wire
